// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing a single-port program memory between the CPU fetch port
// and the host loader port; host_lock gives the host every contested arbitration.
module imem_arbiter #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_lock,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t state, state_next;

  logic last_host;
  logic lat_host;
  logic lat_rw;

  logic any_req;
  logic pick_host;

  logic          cpu_gnt_d, host_gnt_d;
  logic          cpu_rvalid_d, host_rvalid_d;
  logic [DW-1:0] cpu_rdata_d, host_rdata_d;
  logic          mem_en_d, mem_rw_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic          busy_d;

  assign any_req   = cpu_req | host_req;
  // A tie goes to the host under lock, otherwise to whoever did not win last time.
  assign pick_host = host_req & (~cpu_req | host_lock | ~last_host);

  // The mem_addr/mem_wdata registers double as the address/data latch for the access.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= S_IDLE;
      last_host   <= 1'b1;
      lat_host    <= 1'b0;
      lat_rw      <= 1'b0;
      cpu_gnt     <= 1'b0;
      host_gnt    <= 1'b0;
      cpu_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
      cpu_rdata   <= '0;
      host_rdata  <= '0;
      mem_en      <= 1'b0;
      mem_rw      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      cpu_gnt     <= cpu_gnt_d;
      host_gnt    <= host_gnt_d;
      cpu_rvalid  <= cpu_rvalid_d;
      host_rvalid <= host_rvalid_d;
      cpu_rdata   <= cpu_rdata_d;
      host_rdata  <= host_rdata_d;
      mem_en      <= mem_en_d;
      mem_rw      <= mem_rw_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      busy        <= busy_d;
      if (state == S_IDLE && any_req) begin
        last_host <= pick_host;
        lat_host  <= pick_host;
        lat_rw    <= pick_host & host_we;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (any_req) state_next = S_ISSUE;
      S_ISSUE: state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_gnt_d     = 1'b0;
    host_gnt_d    = 1'b0;
    cpu_rvalid_d  = 1'b0;
    host_rvalid_d = 1'b0;
    cpu_rdata_d   = cpu_rdata;
    host_rdata_d  = host_rdata;
    mem_en_d      = 1'b0;
    mem_rw_d      = 1'b0;
    mem_addr_d    = '0;
    mem_wdata_d   = '0;
    busy_d        = (state_next != S_IDLE);
    case (state)
      S_IDLE: begin
        if (any_req) begin
          cpu_gnt_d   = ~pick_host;
          host_gnt_d  = pick_host;
          mem_en_d    = 1'b1;
          mem_rw_d    = pick_host & host_we;
          mem_addr_d  = pick_host ? host_addr : cpu_addr;
          mem_wdata_d = pick_host ? host_wdata : '0;
        end
      end
      S_RESP: begin
        // Memory data is valid during this cycle; register it so rvalid lines up with S_IDLE.
        if (!lat_rw) begin
          if (lat_host) begin
            host_rvalid_d = 1'b1;
            host_rdata_d  = mem_rdata;
          end else begin
            cpu_rvalid_d = 1'b1;
            cpu_rdata_d  = mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural 16x32 synchronous memory and a
// read-data scoreboard fed when each read is driven and drained on every rvalid.
module tb_imem_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_lock = 1'b0;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_en, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  imem_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Rst(Rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_lock(host_lock), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Behavioural memory: read data appears the cycle after an enabled read.
  logic [DW-1:0] mem [16];
  bit mem_ready = 1'b0;
  always @(posedge Clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE0000 + 32'(i);
      mem_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_rw) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp_cpu [$];
  logic [DW-1:0] exp_host [$];
  logic [DW-1:0] exp_mon;
  int gnt_who [$];
  int gnt_cyc [$];
  int cpu_gnt_cnt = 0;
  int host_gnt_cnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h, required %h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (cpu_gnt === 1'b1) begin
      cpu_gnt_cnt++;
      gnt_who.push_back(0);
      gnt_cyc.push_back(cyc);
    end
    if (host_gnt === 1'b1) begin
      host_gnt_cnt++;
      gnt_who.push_back(1);
      gnt_cyc.push_back(cyc);
    end
    if (cpu_rvalid === 1'b1) begin
      if (exp_cpu.size() == 0) checkOutput("cpu_unexpected_rvalid", 32'(cpu_rvalid), 32'd0);
      else begin
        exp_mon = exp_cpu.pop_front();
        checkOutput("cpu_rdata", cpu_rdata, exp_mon);
      end
    end
    if (host_rvalid === 1'b1) begin
      if (exp_host.size() == 0) checkOutput("host_unexpected_rvalid", 32'(host_rvalid), 32'd0);
      else begin
        exp_mon = exp_host.pop_front();
        checkOutput("host_rdata", host_rdata, exp_mon);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic waitGnt(input bit host);
    for (int i = 0; i < 30 && ((host ? host_gnt : cpu_gnt) !== 1'b1); i++) step();
  endtask

  task automatic applyStimulusHost(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    if (we) ref_mem[a] = d;
    else    exp_host.push_back(ref_mem[a]);
    waitGnt(1'b1);
    checkOutput("host_gnt", 32'(host_gnt), 32'd1);
    checkOutput("host_mem_en", 32'(mem_en), 32'd1);
    checkOutput("host_mem_addr", 32'(mem_addr), 32'(a));
    checkOutput("host_mem_rw", 32'(mem_rw), 32'(we));
    if (we) checkOutput("host_mem_wdata", mem_wdata, d);
    host_req = 1'b0;
    step();
    step();
    checkOutput("host_rvalid_at_t3", 32'(host_rvalid), 32'(!we));
    checkOutput("host_no_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    step();
  endtask

  task automatic applyStimulusCpu(input logic [AW-1:0] a);
    cpu_req = 1'b1; cpu_addr = a;
    exp_cpu.push_back(ref_mem[a]);
    waitGnt(1'b0);
    checkOutput("cpu_gnt", 32'(cpu_gnt), 32'd1);
    checkOutput("cpu_mem_addr", 32'(mem_addr), 32'(a));
    checkOutput("cpu_mem_rw", 32'(mem_rw), 32'd0);
    cpu_req = 1'b0;
    step();
    checkOutput("resp_mem_en", 32'(mem_en), 32'd0);
    checkOutput("resp_mem_addr", 32'(mem_addr), 32'd0);
    step();
    checkOutput("cpu_rvalid_at_t3", 32'(cpu_rvalid), 32'd1);
    checkOutput("cpu_no_host_rvalid", 32'(host_rvalid), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c0, h0, hcyc;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'hC0DE0000 + 32'(i);

    // Reset held two cycles with both requesters already asking.
    Rst = 1'b1; cpu_req = 1'b1; cpu_addr = 4'd1; host_req = 1'b1; host_we = 1'b0; host_addr = 4'd2;
    step();
    step();
    checkOutput("rst_ctrl", 32'({cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_en, mem_rw, busy}), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_cpu_rdata", cpu_rdata, 32'd0);
    checkOutput("rst_host_rdata", host_rdata, 32'd0);

    // Contention without lock: CPU, host, CPU, host.
    exp_cpu.push_back(ref_mem[1]); exp_cpu.push_back(ref_mem[1]);
    exp_host.push_back(ref_mem[2]); exp_host.push_back(ref_mem[2]);
    Rst = 1'b0;
    for (int i = 0; i < 40 && gnt_who.size() < 4; i++) step();
    cpu_req = 1'b0; host_req = 1'b0;
    checkOutput("cont_gnt_count", 32'(gnt_who.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("cont_who_%0d", i), 32'(i < gnt_who.size() ? gnt_who[i] : 99), 32'(i % 2));
    for (int i = 1; i < 4; i++)
      checkOutput($sformatf("cont_spacing_%0d", i),
                  32'(i < gnt_cyc.size() ? gnt_cyc[i] - gnt_cyc[i-1] : 0), 32'd3);
    step(); step(); step();

    // Host write then CPU readback of the same word.
    applyStimulusHost(1'b1, 4'd3, 32'h20010005);
    applyStimulusCpu(4'd3);

    // Locked host burst over the whole array while the CPU keeps asking for addr 5.
    c0 = cpu_gnt_cnt; h0 = host_gnt_cnt; hcyc = 0;
    host_lock = 1'b1; cpu_req = 1'b1; cpu_addr = 4'd5; host_req = 1'b1; host_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i);
      host_wdata = 32'hA5000000 + 32'(i * 32'h111);
      ref_mem[i] = host_wdata;
      waitGnt(1'b1);
      hcyc = cyc;
      step();
    end
    host_req = 1'b0; host_lock = 1'b0;
    checkOutput("lock_host_gnts", 32'(host_gnt_cnt - h0), 32'd16);
    checkOutput("lock_cpu_gnts", 32'(cpu_gnt_cnt - c0), 32'd0);
    exp_cpu.push_back(ref_mem[5]);
    waitGnt(1'b0);
    checkOutput("unlock_cpu_gnt", 32'(cpu_gnt), 32'd1);
    checkOutput("unlock_cpu_delay", 32'(cyc - hcyc), 32'd3);
    cpu_req = 1'b0;
    step(); step();
    checkOutput("unlock_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    step();

    // Reset lands while a CPU read of addr 2 is in its response cycle.
    cpu_req = 1'b1; cpu_addr = 4'd2;
    waitGnt(1'b0);
    checkOutput("midrst_cpu_gnt", 32'(cpu_gnt), 32'd1);
    cpu_req = 1'b0;
    step();
    Rst = 1'b1;
    step();
    checkOutput("midrst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    checkOutput("midrst_cpu_rdata", cpu_rdata, 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    Rst = 1'b0;
    step();
    checkOutput("midrst_cpu_rvalid_late", 32'(cpu_rvalid), 32'd0);

    // Host readback of the last word after writing all ones.
    applyStimulusHost(1'b1, 4'd15, 32'hFFFFFFFF);
    applyStimulusHost(1'b0, 4'd15, 32'h0);
    checkOutput("readback_cpu_rdata_held", cpu_rdata, 32'd0);

    step(); step();
    checkOutput("sb_cpu_drained", 32'(exp_cpu.size()), 32'd0);
    checkOutput("sb_host_drained", 32'(exp_host.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
